// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: steers the paired address counter and emits per-cycle memory op strobes.
// Outputs are decoded from the registered state and element, plus the counter wrap flag.
module mbist_march_ctrl #(
  parameter int unsigned length = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cout,
  output logic              ld,
  output logic              u_d,
  output logic              cen,
  output logic [length-1:0] d_in,
  output logic              mem_en,
  output logic              rwrbar,
  output logic              data_inv,
  output logic [2:0]        elem,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ELEM_W    = 3;
  localparam logic [ELEM_W-1:0] LAST_ELEM  = ELEM_W'(5);
  localparam logic [ELEM_W-1:0] FIRST_DOWN = ELEM_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_OP0,
    S_OP1,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;

  // Element table decode: direction, op count and strobes for each op slot
  logic dir_up;
  logic two_op;
  logic op0_rd;
  logic op0_inv;
  logic op1_inv;

  always_comb begin
    dir_up  = (elem_q < FIRST_DOWN);
    two_op  = 1'b0;
    op0_rd  = 1'b1;
    op0_inv = 1'b0;
    op1_inv = 1'b0;
    case (elem_q)
      3'd0: op0_rd = 1'b0;
      3'd1: begin two_op = 1'b1; op1_inv = 1'b1; end
      3'd2: begin two_op = 1'b1; op0_inv = 1'b1; end
      3'd3: begin two_op = 1'b1; op1_inv = 1'b1; end
      3'd4: begin two_op = 1'b1; op0_inv = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
    end
  end

  // Next state and strobes; cen only on the last op of an address so all ops share one q
  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    ld       = 1'b0;
    u_d      = 1'b0;
    cen      = 1'b0;
    d_in     = '0;
    mem_en   = 1'b0;
    rwrbar   = 1'b0;
    data_inv = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_LOAD;
          elem_d  = '0;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        ld      = 1'b1;
        cen     = 1'b1;
        u_d     = dir_up;
        d_in    = dir_up ? '0 : '1;
        state_d = S_OP0;
      end

      S_OP0: begin
        busy = 1'b1;
        u_d  = dir_up;
        if (cout) begin
          if (elem_q == LAST_ELEM) begin
            state_d = S_DONE;
          end else begin
            elem_d  = elem_q + ELEM_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          mem_en   = 1'b1;
          rwrbar   = op0_rd;
          data_inv = op0_inv;
          if (two_op) begin
            state_d = S_OP1;
          end else begin
            cen = 1'b1;
          end
        end
      end

      // A wrap flag here cannot come from a correct counter; the second op always completes
      S_OP1: begin
        busy     = 1'b1;
        u_d      = dir_up;
        mem_en   = 1'b1;
        rwrbar   = 1'b0;
        data_inv = op1_inv;
        cen      = 1'b1;
        state_d  = S_OP0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign elem = elem_q;

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- March C- sequencer for the MBIST engine; sits directly upstream of the address counter.
- Drives the counter's load, direction and enable inputs, and consumes its `cout` wrap flag to end each march element.
- Emits per-cycle memory op strobes (enable, read/write, data polarity) to the memory wrapper and comparator.
- The address itself comes from counter `q`; this block never sees it.

Parameters:
- length, 10, address width; must equal the paired counter's `length`; N = 2^length addresses.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a full March C- pass; ignored unless state is IDLE or DONE
- cout  in  1  counter wrap flag; registered, high the cycle after q wraps, cleared by a load
- ld  out  1  counter parallel load
- u_d  out  1  counter direction: 1 = up, 0 = down
- cen  out  1  counter enable
- d_in  out  length  counter load value
- mem_en  out  1  memory access this cycle
- rwrbar  out  1  1 = read, 0 = write; valid when mem_en=1
- data_inv  out  1  write data / read expectation: 0 = all-zeros, 1 = all-ones
- elem  out  3  current march element index 0..5
- busy  out  1  high from LOAD of element 0 through the last element's exit
- done  out  1  level, high in DONE; cleared by start or rst

Behaviour:
- Reset: state=IDLE, elem=0; all outputs 0.
- Element table (dir, ops):
  - E0 up: w0
  - E1 up: r0, w1
  - E2 up: r1, w0
  - E3 down: r0, w1
  - E4 down: r1, w0
  - E5 down: r0
- States: IDLE, LOAD, OP0, OP1, DONE.
- IDLE/DONE:
  - ld=cen=mem_en=0, u_d=0, d_in=0.
  - start → LOAD with elem=0, done cleared, busy=1.
- LOAD (1 cycle):
  - ld=1, cen=1, u_d=dir(elem).
  - d_in = 0 for up elements, all-ones for down elements.
  - Next state is OP0. The load clears counter cout.
- OP0, first op of an address:
  - If cout=1, the element is complete: mem_en=0, cen=0.
    - elem<5: elem+1 → LOAD.
    - elem=5: → DONE, busy=0, done=1.
  - Else: mem_en=1; rwrbar/data_inv from op0.
    - Single-op element: cen=1, stay in OP0.
    - Two-op element: cen=0 → OP1.
- OP1: mem_en=1, op1 strobes, cen=1 → OP0.
- Ordering and direction:
  - cen is asserted only on the last op of each address, so all ops of an address see the same q.
  - u_d is held at dir(elem) through LOAD/OP0/OP1; ld=0 outside LOAD.
- Timing:
  - Cycles per element = 1 + N·k + 1, where k = ops per element.
  - Full pass = 12 + 10N cycles from the start-sampled edge to done rising; N=4 gives 52.
- Boundary conditions:
  - start while busy: ignored.
  - start in DONE: restarts a fresh pass.
  - start and rst together: rst wins.
  - rst mid-element: next cycle is IDLE with all outputs 0; no partial pass is resumed.
  - cout=1 seen in OP1: illegal for a correct counter and ignored; OP1 always completes.
- Outputs are combinational from state/elem/cout; state and elem are registered.

Test Plan:
- Bench: length=2 (N=4), paired with the real counter; log (elem, q, mem_en, rwrbar, data_inv) every cycle.
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, release, no start for 5 cycles.
  - Required: ld=cen=mem_en=busy=done=0 and elem=0 throughout.
- Full pass:
  - Stimulus: 1-cycle start pulse.
  - Required: done rises exactly 52 cycles later.
  - Memory op sequence is exactly:
    - E0: w0 at q=0,1,2,3
    - E1: (r0,w1) per q=0..3
    - E2: (r1,w0) per q=0..3
    - E3: (r0,w1) per q=3..0
    - E4: (r1,w0) per q=3..0
    - E5: r0 at q=3,2,1,0
  - 40 mem_en cycles total.
- Element boundaries:
  - Every LOAD cycle has ld=1.
  - d_in=0 for E0–E2 and 3 for E3–E5.
  - The OP0 cycle after each wrap has cout=1, mem_en=0, cen=0.
- start while busy:
  - Stimulus: pulse start at cycle 20 of a pass.
  - Required: no effect; done still at cycle 52 and the op sequence is unchanged.
- Reset mid-operation:
  - Stimulus: rst during E3 OP1.
  - Required: next cycle IDLE with all outputs 0.
  - A following start produces a complete 52-cycle pass from E0.
- Restart from DONE:
  - Stimulus: start while done=1.
  - Required: done drops the next cycle, LOAD of E0 with d_in=0, u_d=1, and a second identical pass.
